ulight_fifo_read_data_fifo_rx: RTL and testbench

- Avalon-MM slave that drains the SpaceWire RX data FIFO and presents received 9-bit characters (8 data bits plus 1 control/EOP flag) to the host CPU.
- Sits between the uLight RX FIFO read port and the Avalon interconnect. It is the receive-side counterpart of the TX write-data port.
- Holds a small prefetch buffer so back-to-back CPU reads see no FIFO read latency.
- Provides status, underflow detection and a data-available interrupt.

---
 rtl/ulight_fifo_read_data_fifo_rx.sv | 140 ++++++++++++++
 tb/tb_ulight_fifo_read_data_fifo_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ulight_fifo_read_data_fifo_rx.sv
// Avalon-MM slave that prefetches 9-bit SpaceWire RX characters into a small buffer
// and serves them to the CPU with status, sticky underflow and a data-available irq.
module ulight_fifo_read_data_fifo_rx #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rdreq,
    output logic              irq
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_E = (CNT_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              pending_q;
    logic              irq_en_q;
    logic              underflow_q;
    logic              irq_q;
    logic [31:0]       readdata_q;
    logic [31:0]       rdata_mux;

    logic              rd_cs;
    logic              wr_cs;
    logic              rd_data;
    logic              wr_ctrl;
    logic              push;
    logic              pop;
    logic              buf_empty;
    logic [CNT_W:0]    committed;
    logic [DATA_W-1:0] head;

    assign rd_cs     = chipselect && read;
    assign wr_cs     = chipselect && !write_n;
    assign rd_data   = rd_cs && (address == ADDR_DATA);
    assign wr_ctrl   = wr_cs && (address == ADDR_CTRL);
    assign buf_empty = (count_q == '0);
    assign push      = pending_q;
    assign pop       = rd_data && !buf_empty;
    assign head      = mem_q[rd_ptr_q];

    // Requests already in flight reserve a slot, so the buffer can never overrun.
    assign committed  = {1'b0, count_q} + (CNT_W + 1)'(pending_q);
    assign fifo_rdreq = !reset && !fifo_empty && (committed < DEPTH_E);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rdata_mux = '0;
        case (address)
            ADDR_DATA: begin
                if (!buf_empty) begin
                    rdata_mux[31]         = 1'b1;
                    rdata_mux[DATA_W-1:0] = head;
                end
            end
            ADDR_STATUS: begin
                rdata_mux[CNT_W-1:0] = count_q;
                rdata_mux[8]         = buf_empty;
                rdata_mux[9]         = (count_q == DEPTH_C);
                rdata_mux[10]        = underflow_q;
                rdata_mux[11]        = fifo_empty;
            end
            ADDR_CTRL: rdata_mux[0] = irq_en_q;
            default:   rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= 1'b0;
            irq_en_q    <= 1'b0;
            underflow_q <= 1'b0;
            irq_q       <= 1'b0;
            readdata_q  <= '0;
        end else begin
            pending_q <= fifo_rdreq;
            count_q   <= count_d;
            irq_q     <= irq_en_q && !buf_empty;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (rd_cs) begin
                readdata_q <= rdata_mux;
            end
            if (wr_ctrl) begin
                irq_en_q <= writedata[0];
            end
            if (wr_ctrl && writedata[1]) begin
                underflow_q <= 1'b0;
            end else if (rd_data && buf_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; a word in flight during reset is simply not captured.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= fifo_rdata;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_ulight_fifo_read_data_fifo_rx.sv
// Randomised scoreboard bench for the RX read-data port: a queue-based model of the
// RX FIFO, prefetch buffer and register file predicts every read, irq and fifo_rdreq.
module tb_ulight_fifo_read_data_fifo_rx;

    localparam int unsigned DATA_W = 9;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              read;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_rdreq;
    logic              irq;

    always #5 clk = ~clk;

    ulight_fifo_read_data_fifo_rx #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .read      (read),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_rdreq(fifo_rdreq),
        .irq       (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]       exp_q[$];     // expected readdata, in issue order
    logic [DATA_W-1:0] src_q[$];     // RX FIFO words not yet requested
    logic [DATA_W-1:0] mdl_buf[$];   // model prefetch buffer
    logic              mdl_pend      = 1'b0;
    logic [DATA_W-1:0] mdl_pend_word = '0;
    logic              mdl_irq_en    = 1'b0;
    logic              mdl_uflow     = 1'b0;
    logic              mdl_irq       = 1'b0;
    logic              started       = 1'b0;
    logic              last_rdreq    = 1'b0;
    logic              rd_valid      = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: readdata is valid the cycle after a qualified read strobe.
    always @(posedge clk) rd_valid <= !reset && chipselect && read;

    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: got 0x%08h, expected no read", readdata);
            end else begin
                chk("readdata", readdata, exp_q.pop_front());
            end
        end
    end

    // One bus cycle: drive inputs, check fifo_rdreq/irq, then advance the model.
    task automatic cyc(input logic rst, input logic cs, input logic rd, input logic wr,
                       input logic [1:0] a, input logic [31:0] wd);
        logic        exp_rdreq;
        logic [31:0] exp_rd;
        int          cnt;
        @(negedge clk);
        if (started) chk("irq", {31'b0, irq}, {31'b0, mdl_irq});
        reset      = rst;
        chipselect = cs;
        read       = rd;
        write_n    = !wr;
        address    = a;
        writedata  = wd;
        fifo_empty = (src_q.size() == 0);
        fifo_rdata = mdl_pend ? mdl_pend_word : DATA_W'($urandom);
        cnt        = mdl_buf.size();
        exp_rdreq  = !rst && !fifo_empty && (cnt + int'(mdl_pend) < DEPTH);
        #1;
        if (started) chk("fifo_rdreq", {31'b0, fifo_rdreq}, {31'b0, exp_rdreq});
        last_rdreq = fifo_rdreq;
        if (rst) begin
            mdl_buf.delete();
            mdl_pend   = 1'b0;
            mdl_irq_en = 1'b0;
            mdl_uflow  = 1'b0;
            mdl_irq    = 1'b0;
        end else begin
            if (cs && rd) begin
                case (a)
                    2'd0: exp_rd = (cnt > 0) ? {1'b1, 22'b0, mdl_buf[0]} : 32'h0;
                    2'd1: exp_rd = {20'b0, fifo_empty, mdl_uflow, cnt == DEPTH, cnt == 0,
                                    5'b0, 3'(cnt)};
                    2'd2: exp_rd = {31'b0, mdl_irq_en};
                    default: exp_rd = 32'h0;
                endcase
                exp_q.push_back(exp_rd);
            end
            mdl_irq = mdl_irq_en && (cnt != 0);
            if (cs && rd && a == 2'd0 && cnt > 0) void'(mdl_buf.pop_front());
            if (mdl_pend) mdl_buf.push_back(mdl_pend_word);
            if (cs && wr && a == 2'd2 && wd[1]) mdl_uflow = 1'b0;
            else if (cs && rd && a == 2'd0 && cnt == 0) mdl_uflow = 1'b1;
            if (cs && wr && a == 2'd2) mdl_irq_en = wd[0];
            mdl_pend = exp_rdreq;
            if (exp_rdreq) mdl_pend_word = src_q.pop_front();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic bus_rd(input logic [1:0] a);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, a, d);
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        read       = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        fifo_empty = 1'b1;
        fifo_rdata = '0;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        started = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        idle(1);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);

        // Three words, then drain
        src_q.push_back(9'h041);
        src_q.push_back(9'h142);
        src_q.push_back(9'h043);
        idle(5);
        bus_rd(2'd1);
        for (int i = 0; i < 3; i++) bus_rd(2'd0);
        bus_rd(2'd1);
        idle(2);

        // Six words against a four-entry buffer, read back across the wrap
        for (int i = 0; i < 6; i++) src_q.push_back(DATA_W'(9'h0a0 + i));
        idle(8);
        bus_rd(2'd1);
        for (int i = 0; i < 6; i++) begin
            bus_rd(2'd0);
            idle(1);
            bus_rd(2'd1);
        end
        idle(3);

        // Underflow set and cleared
        bus_rd(2'd0);
        bus_rd(2'd1);
        bus_wr(2'd2, 32'h2);
        bus_rd(2'd1);
        bus_rd(2'd2);

        // Interrupt enable, rise on data, drop after drain, stays low when disabled
        bus_wr(2'd2, 32'h1);
        bus_rd(2'd2);
        src_q.push_back(9'h155);
        idle(4);
        bus_rd(2'd0);
        idle(3);
        bus_wr(2'd2, 32'h0);
        src_q.push_back(9'h0aa);
        idle(4);
        bus_rd(2'd0);
        idle(2);

        // Streaming with back-to-back reads
        for (int i = 0; i < 16; i++) src_q.push_back(DATA_W'($urandom));
        for (int i = 0; i < 28; i++) bus_rd(2'd0);
        bus_rd(2'd1);
        idle(2);

        // Reset on the cycle after a request: in-flight word is discarded
        bus_wr(2'd2, 32'h1);
        src_q.push_back(9'h1ff);
        begin
            int waited = 0;
            do begin
                idle(1);
                waited++;
            end while (!last_rdreq && waited < 10);
            if (!last_rdreq) begin
                n_checks++;
                n_fail++;
                $display("FAIL rdreq_timeout: got no fifo_rdreq, expected one within 10 cycles");
            end
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        bus_rd(2'd1);
        idle(3);
        chk("post_reset_irq", {31'b0, irq}, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int op;
            if (src_q.size() < 8 && $urandom_range(3) == 0) src_q.push_back(DATA_W'($urandom));
            op = $urandom_range(11);
            case (op)
                0, 1, 2, 3: bus_rd(2'd0);
                4:       bus_rd(2'd1);
                5:       bus_rd(2'd2);
                6:       bus_rd(2'd3);
                7:       bus_wr(2'd2, {30'b0, 2'($urandom)});
                8:       bus_wr(2'($urandom_range(1) * 3), $urandom);
                9:       cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
                10:      cyc(($urandom_range(30) == 0), 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
                default: idle(1);
            endcase
        end
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
